sobel_frame_ctrl: RTL

//  Frame-level sequencer for the Sobel accelerator. On start, scans the input image RAM in raster

---
 rtl/sobel_frame_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer that scans the input RAM in raster order, counts output writes and signals completion
// Ports: clk/rst (sync, active-high); start, stall, wr_en in; busy, done, frame_err out;
//   rd_en/rd_addr drive the input RAM; pix_valid/pix_row/pix_col tag RAM data one cycle later;
//   clr_wr_en/clr_addr zero the border of the output image.
// Build option: define BORDER_CLEAR_EN to add the CLEAR state; otherwise the clear port is tied 0.
module sobel_frame_ctrl #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int ADDR_W = 8,
  parameter int DRAIN_MAX = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     frame_err,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     pix_valid,
  output logic [$clog2(IMG_H)-1:0] pix_row,
  output logic [$clog2(IMG_W)-1:0] pix_col,
  output logic                     clr_wr_en,
  output logic [ADDR_W-1:0]        clr_addr
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int T = (IMG_H - 2) * (IMG_W - 2);
  localparam int NW = $clog2(T + 1);
  localparam int DW = $clog2(DRAIN_MAX);
  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
`ifdef BORDER_CLEAR_EN
    CLEAR,
`endif
    DONE
  } state_t;
  state_t state, nxt, drain_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [NW-1:0] cnt;
  logic [DW-1:0] tmr;
  logic [ADDR_W-1:0] addr;
  logic last_row, last_col, issue, cnt_en, full, timeout, jump;
  assign last_row = row == RW'(IMG_H - 1);
  assign last_col = col == CW'(IMG_W - 1);
  assign issue = state == READ && !stall;
  assign cnt_en = wr_en && (state == READ || state == DRAIN);
  // a write landing this very cycle already counts toward the exit decision
  assign full = cnt == NW'(T) || (cnt_en && cnt == NW'(T - 1));
  assign timeout = tmr == DW'(DRAIN_MAX - 1);
  assign addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
`ifdef BORDER_CLEAR_EN
  assign drain_next = CLEAR;
  assign clr_wr_en = state == CLEAR;
  assign clr_addr = clr_wr_en ? addr : '0;
`else
  assign drain_next = DONE;
  assign clr_wr_en = 1'b0;
  assign clr_addr = '0;
`endif
  // interior rows of the border walk only touch col 0 and col IMG_W-1
  assign jump = clr_wr_en && row != '0 && !last_row;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rd_en = issue;
  assign rd_addr = issue ? addr : '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? READ : IDLE;
      READ:    nxt = issue && last_row && last_col ? DRAIN : READ;
      DRAIN:   nxt = full || timeout ? drain_next : DRAIN;
`ifdef BORDER_CLEAR_EN
      CLEAR:   nxt = last_row && last_col ? DONE : CLEAR;
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      cnt <= '0;
      tmr <= '0;
      frame_err <= 1'b0;
      pix_valid <= 1'b0;
      pix_row <= '0;
      pix_col <= '0;
    end else begin
      state <= nxt;
      pix_valid <= rd_en;
      pix_row <= row;
      pix_col <= col;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
        cnt <= '0;
        tmr <= '0;
        frame_err <= 1'b0;
      end
      // the final step of a scan returns row/col to 0, ready for the next walk
      if (issue || clr_wr_en) begin
        col <= last_col ? '0 : jump ? CW'(IMG_W - 1) : col + 1'b1;
        row <= !last_col ? row : last_row ? '0 : row + 1'b1;
      end
      if (cnt_en && cnt != NW'(T)) cnt <= cnt + 1'b1;
      if (state == DRAIN) tmr <= tmr + 1'b1;
      if (state == DRAIN && timeout && !full) frame_err <= 1'b1;
    end
  end
endmodule
